// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, mid-bit sampling, LSB-first shift-in.
// Presents each byte with a one-cycle rx_done strobe and a stop-bit framing flag.
module uart_receiver #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done,
  output logic             frame_err,
  output logic [1:0]       state_out
);

  // state | meaning
  // IDLE  | line idle, waiting for rx_sync to fall
  // START | counting to mid start bit, rejecting glitches
  // DATA  | sampling DBITS data bits at mid-bit
  // STOP  | waiting SB_TICK ticks, then checking stop bit and presenting byte
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(7);
  localparam logic [TW-1:0] TICK_LAST = TW'(15);
  localparam logic [TW-1:0] TICK_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

  logic             rx_s1;
  logic             rx_sync;
  state_t           state, state_next;
  logic [TW-1:0]    tick_cnt, tick_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic [DBITS-1:0] shift_reg, shift_next;
  logic [DBITS-1:0] data_next;
  logic             err_next;
  logic             done_next;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      data_out  <= data_next;
      frame_err <= err_next;
      rx_done   <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    data_next  = data_out;
    err_next   = frame_err;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_sync) begin
              state_next = DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next  = '0;
            shift_next = {rx_sync, shift_reg[DBITS-1:1]};
            if (bit_cnt == BIT_LAST) state_next = STOP;
            else                     bit_next   = bit_cnt + BW'(1);
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start bit be caught a clock later.
        if (sample_tick) begin
          if (tick_cnt == TICK_STOP) begin
            data_next  = shift_reg;
            err_next   = ~rx_sync;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign state_out = state;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage. It is the counterpart of `uart_transmitter` and shares its `sample_tick` from `baud_rate_generator` (16× oversampling). It synchronises the asynchronous `rx` line, validates the start bit at mid-bit, and shifts in `DBITS` data bits LSB-first. It checks the stop bit, then presents the byte with a one-cycle `rx_done` strobe and a framing-error flag. In the top-level it drives the `rx_out` LED view and feeds the downstream receive FIFO.

## Interface
- `DBITS`, 8: data bits per frame.
- `SB_TICK`, 16: oversampling ticks spanned by the stop bit. 16 means 1 stop bit.
- `clk_100MHz`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk_100MHz`.
- `sample_tick`  in  1  oversampling enable. Every clock cycle it is high counts as one tick.
- `data_out`  out  DBITS  last received byte. Held until the next frame completes.
- `rx_done`  out  1  one-clock pulse when `data_out`/`frame_err` update.
- `frame_err`  out  1  1 if the last frame's stop bit sampled low. Held like `data_out`.
- `state_out`  out  2  current FSM state, for debug LEDs.

## Operation
- Input synchroniser:
  - Two-flop chain `rx` → `rx_s1` → `rx_sync`. Both flops reset to 1.
  - All decisions use `rx_sync` only.
- Counters:
  - `tick_cnt`, 4 bits. Wide enough for 15 and for `SB_TICK-1`; widen it if `SB_TICK` > 16.
  - `bit_cnt`, $clog2(DBITS) bits.
  - `shift_reg`, DBITS bits.
- FSM encoding: IDLE=00, START=01, DATA=10, STOP=11. `state_out` = state register.
- IDLE: when `rx_sync`==0, go to START and set `tick_cnt`=0. `sample_tick` is not needed for this transition.
- START, on `sample_tick` only:
  - If `tick_cnt`==7 and `rx_sync`==0: go to DATA, `tick_cnt`=0, `bit_cnt`=0.
  - If `tick_cnt`==7 and `rx_sync`==1: treat as a glitch, return to IDLE. `rx_done` stays 0 and no output changes.
  - Otherwise `tick_cnt`++.
- DATA, on `sample_tick` only:
  - If `tick_cnt`==15: `tick_cnt`=0 and `shift_reg` = {`rx_sync`, `shift_reg`[DBITS-1:1]} (LSB first).
    - If `bit_cnt`==DBITS-1, go to STOP.
    - Otherwise `bit_cnt`++.
  - Otherwise `tick_cnt`++.
- STOP, on `sample_tick` only:
  - If `tick_cnt`==SB_TICK-1: `data_out`=`shift_reg`, `frame_err`=~`rx_sync`, `rx_done`=1 for this cycle only, go to IDLE.
  - Otherwise `tick_cnt`++.
- A framing error still delivers the byte and still pulses `rx_done`.
- Outputs change only in the STOP-completion cycle. `rx_done` is 0 in every other cycle.
- Reset value of every output and register:
  - IDLE state, counters 0, `shift_reg` 0.
  - `data_out`=0, `rx_done`=0, `frame_err`=0, `state_out`=00.
  - Reset mid-frame aborts with no `rx_done`.

## Timing
- Synchroniser latency: 2 clocks from an `rx` edge to `rx_sync`.
- IDLE→START takes 1 clock after `rx_sync` falls.
- Sampling points:
  - Start bit is sampled at tick 8, which is mid-bit.
  - Each data bit is sampled 16 ticks later, at mid-bit.
  - Stop bit is sampled `SB_TICK` ticks after the last data bit. This is mid-stop-bit for `SB_TICK`=16.
- Ticks per frame: 8 + 16·DBITS + SB_TICK, counted from START entry. For defaults that is 152.
- `rx_done`, `data_out` and `frame_err` are registered. They update on the clock edge ending the cycle in which `sample_tick`=1 and `tick_cnt`==SB_TICK-1.
- Back-to-back frames:
  - The FSM returns to IDLE mid-stop-bit.
  - If `rx_sync` is already low, the next start bit is accepted 1 clock later.
  - No stop-bit wait-out is required.
- A falling `rx` edge during DATA or STOP is ignored, apart from being sampled as data.
- Break condition (line held low): byte 0x00 with `frame_err`=1. The FSM then re-enters START and repeats while the line stays low.
- A `sample_tick` held high continuously gives one tick per clock. This is legal and used in bench runs.

## Test plan
- Reset release with `rx`=1 and ticks running:
  - All outputs stay 0 and `state_out`=00 for 1000 clocks.
- Frame 0xA5, 1 stop bit, tick every 4 clocks:
  - One `rx_done` pulse, `data_out`=0xA5, `frame_err`=0.
  - `state_out` sequence is 00→01→10→11→00.
- Frames 0x3C then 0xFF back-to-back, no idle gap:
  - Two `rx_done` pulses, `data_out`=0x3C then 0xFF, `frame_err`=0 both times.
- Start glitch (`rx` low for 3 ticks, then high):
  - The FSM returns to 00 at tick 8 with no `rx_done`.
  - `data_out` keeps its previous value.
- Frame 0x5A with the stop bit driven low:
  - `rx_done` pulses, `data_out`=0x5A, `frame_err`=1.
  - A following good frame 0x01 clears `frame_err` to 0.
- `reset` asserted mid-DATA of frame 0x77:
  - Outputs return to 0 asynchronously and no `rx_done` pulses.
  - After release, frame 0x12 is received correctly.
